// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared types and constants for the two-byte UART response path
package comm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } tx_state_t;

    localparam int DEFAULT_BAUD_DIV = 2604;
    localparam int FRAME_BITS       = 10;

endpackage

// File: rtl/resp_word_tx_if.sv
// rtl/resp_word_tx_if.sv - word handshake between control logic and the response transmitter
interface resp_word_tx_if;

    logic [15:0] resp;
    logic        send_resp;
    logic        resp_ready;
    logic        clr_resp_sent;
    logic        resp_sent;
    logic        busy;

    modport master (
        output resp, send_resp, clr_resp_sent,
        input  resp_ready, resp_sent, busy
    );

    modport slave (
        input  resp, send_resp, clr_resp_sent,
        output resp_ready, resp_sent, busy
    );

endinterface

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - 8N1 byte serialiser with registered TX and end-of-frame pulse
module uart_tx_core
    import comm_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       byte_done
);

    localparam int            CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(FRAME_BITS - 1);

    logic [CW-1:0] r_baud;
    logic [3:0]    r_bit;
    logic [8:0]    r_shift;
    logic          r_active;
    logic          r_tx;
    logic          w_bit_end;

    assign w_bit_end = r_active && (r_baud == BAUD_LAST);
    // Combinational so the next byte can be loaded on the very edge the stop bit ends.
    assign byte_done = w_bit_end && (r_bit == BIT_LAST);
    assign TX        = r_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '1;
            r_active <= 1'b0;
            r_tx     <= 1'b1;
        end else if (trmt) begin
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= {1'b1, tx_data};
            r_active <= 1'b1;
            r_tx     <= 1'b0;
        end else if (w_bit_end) begin
            r_baud <= '0;
            if (byte_done) begin
                r_active <= 1'b0;
                r_bit    <= '0;
                r_tx     <= 1'b1;
            end else begin
                r_bit   <= r_bit + 4'd1;
                r_tx    <= r_shift[0];
                r_shift <= {1'b1, r_shift[8:1]};
            end
        end else if (r_active) begin
            r_baud <= r_baud + 1'b1;
        end
    end

endmodule

// File: rtl/resp_word_tx.sv
// rtl/resp_word_tx.sv - queues 16-bit response words and sends them high byte first as two UART frames
module resp_word_tx
    import comm_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic           clk,
    input  logic           rst,
    resp_word_tx_if.slave  bus,
    output logic           TX
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_HIGH = HIGH;
    localparam logic [1:0] ST_LOW  = LOW;

    logic [1:0]  r_state;
    logic [15:0] r_hold;
    logic [15:0] r_word;
    logic        r_hold_valid;
    logic        r_resp_sent;

    logic        w_byte_done;
    logic        w_accept;
    logic        w_load_high;
    logic        w_load_low;
    logic        w_trmt;
    logic [7:0]  w_tx_data;

    assign w_accept    = bus.send_resp && !r_hold_valid;
    assign w_load_high = r_hold_valid &&
                         ((r_state == ST_IDLE) || ((r_state == ST_LOW) && w_byte_done));
    assign w_load_low  = (r_state == ST_HIGH) && w_byte_done;
    assign w_trmt      = w_load_high || w_load_low;
    // Low byte comes from r_word so a newly queued word cannot disturb the one in flight.
    assign w_tx_data   = w_load_low ? r_word[7:0] : r_hold[15:8];

    uart_tx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .trmt      (w_trmt),
        .tx_data   (w_tx_data),
        .TX        (TX),
        .byte_done (w_byte_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_hold       <= '0;
            r_word       <= '0;
            r_hold_valid <= 1'b0;
            r_resp_sent  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold       <= bus.resp;
                r_hold_valid <= 1'b1;
            end else if (w_load_high) begin
                r_hold_valid <= 1'b0;
            end

            if (w_load_high) begin
                r_word <= r_hold;
            end

            case (r_state)
                ST_IDLE: if (w_load_high) r_state <= ST_HIGH;
                ST_HIGH: if (w_byte_done) r_state <= ST_LOW;
                ST_LOW:  if (w_byte_done) r_state <= w_load_high ? ST_HIGH : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            if ((r_state == ST_LOW) && w_byte_done) begin
                r_resp_sent <= 1'b1;
            end else if (bus.clr_resp_sent || w_accept) begin
                r_resp_sent <= 1'b0;
            end
        end
    end

    assign bus.resp_ready = !r_hold_valid;
    assign bus.resp_sent  = r_resp_sent;
    assign bus.busy       = (r_state != ST_IDLE) || r_hold_valid;

endmodule

// File: tb/tb_resp_word_tx.sv
// tb/tb_resp_word_tx.sv - directed self-checking bench for resp_word_tx
module tb_resp_word_tx;

    localparam int BD = 8;

    logic clk = 1'b0;
    logic rst;
    logic tx;

    resp_word_tx_if bus ();

    resp_word_tx #(
        .BAUD_DIV (BD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .TX  (tx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_bytes [0:3];
    logic       rx_frame_ok;
    logic       rdy_at1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after an edge; the following edge is edge 0 of the word.
    task automatic send_word(input logic [15:0] w);
        bus.resp      = w;
        bus.send_resp = 1'b1;
        tick;
        bus.send_resp = 1'b0;
    endtask

    // Starts just after edge 0; samples every cycle, decodes mid-bit, requires each bit constant.
    task automatic sample_line(input int nbytes);
        logic [9:0] f;
        logic [7:0] s;
        rx_frame_ok = 1'b1;
        for (int b = 0; b < nbytes; b++) begin
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < BD; c++) begin
                    tick;
                    if (b == 0 && k == 0 && c == 0) rdy_at1 = bus.resp_ready;
                    s[c] = tx;
                end
                f[k] = s[4];
                if (s !== {8{s[4]}}) rx_frame_ok = 1'b0;
            end
            rx_bytes[b] = f[8:1];
            if (f[0] !== 1'b0 || f[9] !== 1'b1) rx_frame_ok = 1'b0;
        end
    endtask

    initial begin
        logic       idle_ok;
        logic [15:0] lw [0:1];

        rst               = 1'b1;
        bus.resp          = '0;
        bus.send_resp     = 1'b0;
        bus.clr_resp_sent = 1'b0;
        repeat (2) tick;
        rst = 1'b0;

        chk("rst_tx",    32'(tx),             32'd1);
        chk("rst_ready", 32'(bus.resp_ready), 32'd1);
        chk("rst_sent",  32'(bus.resp_sent),  32'd0);
        chk("rst_busy",  32'(bus.busy),       32'd0);
        idle_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick;
            if (tx !== 1'b1 || bus.busy !== 1'b0 || bus.resp_ready !== 1'b1) idle_ok = 1'b0;
        end
        chk("idle_50", 32'(idle_ok), 32'd1);

        // Single word
        send_word(16'h1234);
        chk("w1_ready_e0", 32'(bus.resp_ready), 32'd0);
        chk("w1_busy_e0",  32'(bus.busy),       32'd1);
        chk("w1_tx_e0",    32'(tx),             32'd1);
        sample_line(2);
        chk("w1_ready_e1", 32'(rdy_at1),        32'd1);
        chk("w1_frame",    32'(rx_frame_ok),    32'd1);
        chk("w1_hi",       32'(rx_bytes[0]),    32'h12);
        chk("w1_lo",       32'(rx_bytes[1]),    32'h34);
        chk("w1_sent_160", 32'(bus.resp_sent),  32'd0);
        chk("w1_busy_160", 32'(bus.busy),       32'd1);
        tick;
        chk("w1_sent_161", 32'(bus.resp_sent),  32'd1);
        chk("w1_busy_161", 32'(bus.busy),       32'd0);
        chk("w1_tx_161",   32'(tx),             32'd1);

        // Queued words plus a dropped send
        tick;
        send_word(16'hAF82);
        chk("q_sent_clr", 32'(bus.resp_sent), 32'd0);
        fork
            sample_line(4);
            begin
                repeat (19) tick;
                bus.resp      = 16'h5A5A;
                bus.send_resp = 1'b1;
                tick;
                bus.send_resp = 1'b0;
                chk("q_ready_e20", 32'(bus.resp_ready), 32'd0);
                repeat (9) tick;
                bus.resp      = 16'hFFFF;
                bus.send_resp = 1'b1;
                tick;
                bus.send_resp = 1'b0;
                chk("q_ready_e30", 32'(bus.resp_ready), 32'd0);
            end
        join
        chk("q_frame", 32'(rx_frame_ok), 32'd1);
        chk("q_b0",    32'(rx_bytes[0]), 32'hAF);
        chk("q_b1",    32'(rx_bytes[1]), 32'h82);
        chk("q_b2",    32'(rx_bytes[2]), 32'h5A);
        chk("q_b3",    32'(rx_bytes[3]), 32'h5A);
        chk("q_busy_320", 32'(bus.busy), 32'd1);
        tick;
        chk("q_busy_321", 32'(bus.busy),      32'd0);
        chk("q_sent_321", 32'(bus.resp_sent), 32'd1);
        idle_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (tx !== 1'b1 || bus.busy !== 1'b0) idle_ok = 1'b0;
        end
        chk("q_no_ff", 32'(idle_ok), 32'd1);

        // resp_sent set beats a simultaneous clear
        send_word(16'hC3A5);
        chk("p_sent_clr", 32'(bus.resp_sent), 32'd0);
        repeat (160) tick;
        chk("p_sent_160", 32'(bus.resp_sent), 32'd0);
        bus.clr_resp_sent = 1'b1;
        tick;
        bus.clr_resp_sent = 1'b0;
        chk("p_set_wins", 32'(bus.resp_sent), 32'd1);
        tick;
        bus.clr_resp_sent = 1'b1;
        tick;
        bus.clr_resp_sent = 1'b0;
        chk("p_lone_clr", 32'(bus.resp_sent), 32'd0);

        // Reset mid-frame with a pending word
        send_word(16'h00FF);
        repeat (9) tick;
        send_word(16'h1111);
        repeat (39) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("r_tx",    32'(tx),             32'd1);
        chk("r_busy",  32'(bus.busy),       32'd0);
        chk("r_ready", 32'(bus.resp_ready), 32'd1);
        idle_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (tx !== 1'b1 || bus.busy !== 1'b0) idle_ok = 1'b0;
        end
        chk("r_pending_dropped", 32'(idle_ok), 32'd1);
        send_word(16'h0001);
        sample_line(2);
        chk("r_frame", 32'(rx_frame_ok), 32'd1);
        chk("r_hi",    32'(rx_bytes[0]), 32'h00);
        chk("r_lo",    32'(rx_bytes[1]), 32'h01);
        tick;

        // Receive-side reassembly of extreme words
        lw[0] = 16'h0000;
        lw[1] = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            send_word(lw[i]);
            sample_line(2);
            chk($sformatf("lb%0d_frame", i), 32'(rx_frame_ok), 32'd1);
            chk($sformatf("lb%0d_word", i),  32'({rx_bytes[0], rx_bytes[1]}), 32'(lw[i]));
            chk($sformatf("lb%0d_rdy_pre", i), 32'(bus.resp_sent), 32'd0);
            tick;
            chk($sformatf("lb%0d_rdy", i), 32'(bus.resp_sent), 32'd1);
            tick;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
